// File: rtl/rr_grant_ctrl.sv
// rtl/rr_grant_ctrl.sv - grant-holding controller downstream of a round-robin arbiter
// Holds the arbiter's winner until release, withdrawal or hold limit, then feeds it back as lowp.
module rr_grant_ctrl #(
  parameter int MAX_HOLD = 15,
  parameter int CNT_W    = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [7:0]       reqs_i,
  input  logic [2:0]       arb_grant_i,
  input  logic             arb_any_i,
  input  logic             release_i,
  output logic [2:0]       lowp_o,
  output logic             grant_valid_o,
  output logic [2:0]       grant_idx_o,
  output logic [7:0]       grant_onehot_o,
  output logic             timeout_o,
  output logic [CNT_W-1:0] grant_cnt_o
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_GAP  = 2'd2
  } state_t;

  localparam logic [7:0] HOLD_LAST = 8'(MAX_HOLD - 1);

  state_t           r_state;
  logic [7:0]       r_hold;
  logic [2:0]       r_lowp;
  logic             r_valid;
  logic [2:0]       r_grant_idx;
  logic [7:0]       r_onehot;
  logic             r_timeout;
  logic [CNT_W-1:0] r_cnt;

  logic       w_req_ok;
  logic       w_owner_req;
  logic       w_hold_hit;
  logic       w_release;
  logic       w_forced;
  logic       w_cnt_sat;
  logic [7:0] w_onehot_next;

  // An inconsistent arbiter (winner bit not actually requesting) never produces a grant.
  assign w_req_ok      = arb_any_i & reqs_i[arb_grant_i];
  assign w_owner_req   = reqs_i[r_grant_idx];
  assign w_hold_hit    = (r_hold == HOLD_LAST);
  assign w_release     = release_i | ~w_owner_req | w_hold_hit;
  assign w_forced      = w_hold_hit & ~release_i & w_owner_req;
  assign w_cnt_sat     = &r_cnt;
  assign w_onehot_next = 8'b1 << arb_grant_i;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_hold      <= 8'd0;
      r_lowp      <= 3'd7;
      r_valid     <= 1'b0;
      r_grant_idx <= 3'd0;
      r_onehot    <= 8'd0;
      r_timeout   <= 1'b0;
      r_cnt       <= '0;
    end else begin
      r_timeout <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_req_ok) begin
            r_state     <= S_BUSY;
            r_grant_idx <= arb_grant_i;
            r_onehot    <= w_onehot_next;
            r_valid     <= 1'b1;
            r_hold      <= 8'd0;
          end
        end
        S_BUSY: begin
          if (w_release) begin
            r_state   <= S_GAP;
            r_valid   <= 1'b0;
            r_onehot  <= 8'd0;
            r_lowp    <= r_grant_idx;
            r_timeout <= w_forced;
            if (!w_cnt_sat) begin
              r_cnt <= r_cnt + CNT_W'(1);
            end
          end else begin
            r_hold <= r_hold + 8'd1;
          end
        end
        S_GAP: begin
          // One dead cycle lets the arbiter re-evaluate with the updated lowp.
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign lowp_o         = r_lowp;
  assign grant_valid_o  = r_valid;
  assign grant_idx_o    = r_grant_idx;
  assign grant_onehot_o = r_onehot;
  assign timeout_o      = r_timeout;
  assign grant_cnt_o    = r_cnt;

endmodule

// File: tb/tb_rr_grant_ctrl.sv
// tb/tb_rr_grant_ctrl.sv - scoreboard bench for rr_grant_ctrl with an in-bench arbiter and grant model
module tb_rr_grant_ctrl;
  localparam int MAX_HOLD = 15;
  localparam int CNT_W    = 8;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic [7:0]       reqs = 8'd0;
  logic [2:0]       arb_grant = 3'd0;
  logic             arb_any = 1'b0;
  logic             rel = 1'b0;
  logic [2:0]       lowp_o;
  logic             grant_valid_o;
  logic [2:0]       grant_idx_o;
  logic [7:0]       grant_onehot_o;
  logic             timeout_o;
  logic [CNT_W-1:0] grant_cnt_o;

  always #5 clk = ~clk;

  rr_grant_ctrl #(.MAX_HOLD(MAX_HOLD), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .reqs_i(reqs), .arb_grant_i(arb_grant), .arb_any_i(arb_any),
    .release_i(rel), .lowp_o(lowp_o), .grant_valid_o(grant_valid_o), .grant_idx_o(grant_idx_o),
    .grant_onehot_o(grant_onehot_o), .timeout_o(timeout_o), .grant_cnt_o(grant_cnt_o)
  );

  typedef struct {
    logic       valid;
    logic [2:0] idx;
    logic [7:0] onehot;
    logic       to;
    logic [2:0] lowp;
    logic [7:0] cnt;
  } exp_t;

  exp_t q[$];
  int checks = 0;
  int errors = 0;

  // Reference model: who owns the resource, how many edges it has held it, and whether a cooldown is pending.
  int m_owner, m_age, m_lowp, m_cnt;
  bit m_cool, m_to;

  task automatic model_reset();
    m_owner = -1; m_age = 0; m_lowp = 7; m_cnt = 0; m_cool = 0; m_to = 0;
  endtask

  function automatic exp_t model_exp();
    exp_t e;
    e.valid  = (m_owner >= 0);
    e.idx    = (m_owner >= 0) ? 3'(m_owner) : 3'd0;
    e.onehot = (m_owner >= 0) ? 8'(1 << m_owner) : 8'd0;
    e.to     = m_to;
    e.lowp   = 3'(m_lowp);
    e.cnt    = 8'(m_cnt);
    return e;
  endfunction

  task automatic model_step();
    bit withdrew, expired;
    m_to = 0;
    if (m_cool) begin
      m_cool = 0;
    end else if (m_owner < 0) begin
      if (arb_any && reqs[arb_grant]) begin
        m_owner = int'(arb_grant);
        m_age = 0;
      end
    end else begin
      m_age++;
      withdrew = !reqs[m_owner];
      expired  = (m_age >= MAX_HOLD);
      if (rel || withdrew || expired) begin
        m_to = expired && !rel && !withdrew;
        m_lowp = m_owner;
        if (m_cnt < 255) m_cnt++;
        m_owner = -1;
        m_cool = 1;
      end
    end
  endtask

  function automatic int rr_pick(logic [7:0] r, int lp);
    for (int k = 1; k <= 8; k++) begin
      int i;
      i = (lp + k) % 8;
      if (r[i]) return i;
    end
    return -1;
  endfunction

  task automatic chk(string name, int got, int want);
    checks++;
    if (got != want) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, got, want, $time);
    end
  endtask

  // Apply inputs for one cycle; the arbiter picks from the model's view of lowp.
  task automatic drive(logic [7:0] r, logic rl, bit bad = 0);
    int w;
    reqs = r;
    rel  = rl;
    w = rr_pick(r, m_lowp);
    if (bad && r != 8'hFF) begin
      int s;
      s = int'($urandom % 8);
      for (int k = 0; k < 8; k++) begin
        if (!r[(s + k) % 8]) begin
          arb_grant = 3'((s + k) % 8);
          break;
        end
      end
      arb_any = 1'b1;
    end else if (w >= 0) begin
      arb_any = 1'b1;
      arb_grant = 3'(w);
    end else begin
      arb_any = 1'b0;
      arb_grant = 3'($urandom);
    end
    model_step();
    q.push_back(model_exp());
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset(int n);
    rst = 1'b1;
    #1;
    q.delete();
    model_reset();
    chk("rst_valid", int'(grant_valid_o), 0);
    chk("rst_onehot", int'(grant_onehot_o), 0);
    chk("rst_lowp", int'(lowp_o), 7);
    chk("rst_cnt", int'(grant_cnt_o), 0);
    chk("rst_timeout", int'(timeout_o), 0);
    q.push_back(model_exp());
    repeat (n) begin
      @(posedge clk);
      #1;
      q.push_back(model_exp());
    end
    rst = 1'b0;
  endtask

  always @(negedge clk) begin
    if (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      checks++;
      if (grant_valid_o !== e.valid || grant_onehot_o !== e.onehot || timeout_o !== e.to ||
          lowp_o !== e.lowp || grant_cnt_o !== e.cnt || (e.valid && grant_idx_o !== e.idx)) begin
        errors++;
        $display("FAIL scoreboard t=%0t: got v=%b idx=%0d oh=%h to=%b lowp=%0d cnt=%0d, expected v=%b idx=%0d oh=%h to=%b lowp=%0d cnt=%0d",
                 $time, grant_valid_o, grant_idx_o, grant_onehot_o, timeout_o, lowp_o, grant_cnt_o,
                 e.valid, e.idx, e.onehot, e.to, e.lowp, e.cnt);
      end
    end
  end

  initial begin
    int got_seq[$];
    int len, tcount;
    bit hit;
    model_reset();
    @(posedge clk);
    #1;

    // Single grant released in its third BUSY cycle.
    apply_reset(1);
    drive(8'h01, 0);
    chk("t1_onehot", int'(grant_onehot_o), 8'h01);
    drive(8'h01, 0);
    drive(8'h01, 0);
    drive(8'h01, 1);
    chk("t1_valid", int'(grant_valid_o), 0);
    chk("t1_lowp", int'(lowp_o), 0);
    chk("t1_cnt", int'(grant_cnt_o), 1);
    drive(8'h00, 0);

    // Full request vector, immediate release: strict rotation.
    apply_reset(1);
    for (int i = 0; i < 40 && got_seq.size() < 9; i++) begin
      drive(8'hFF, 1);
      if (grant_valid_o) got_seq.push_back(int'(grant_idx_o));
    end
    chk("t2_grants", got_seq.size(), 9);
    for (int i = 0; i < got_seq.size(); i++) chk("t2_order", got_seq[i], i % 8);

    // Hold limit on a lone requester.
    apply_reset(1);
    drive(8'h20, 0);
    len = 1;
    tcount = 0;
    for (int i = 0; i < 40; i++) begin
      drive(8'h20, 0);
      if (timeout_o) tcount++;
      if (grant_valid_o) len++;
      else break;
    end
    chk("t3_hold_len", len, MAX_HOLD);
    chk("t3_timeout", int'(timeout_o), 1);
    chk("t3_timeout_count", tcount, 1);
    chk("t3_lowp", int'(lowp_o), 5);
    drive(8'h20, 0);
    chk("t3_pulse_end", int'(timeout_o), 0);
    drive(8'h20, 0);
    chk("t3_regrant", int'(grant_idx_o), 5);
    chk("t3_regrant_valid", int'(grant_valid_o), 1);

    // Requester withdraws during BUSY.
    apply_reset(1);
    drive(8'h08, 0);
    drive(8'h08, 0);
    drive(8'h00, 0);
    chk("t4_valid", int'(grant_valid_o), 0);
    chk("t4_timeout", int'(timeout_o), 0);
    chk("t4_lowp", int'(lowp_o), 3);
    chk("t4_cnt", int'(grant_cnt_o), 1);

    // Reset during a grant to 6, then lowest active index wins.
    apply_reset(1);
    hit = 0;
    for (int i = 0; i < 10; i++) begin
      drive(8'h40, 0);
      if (grant_valid_o) begin hit = 1; break; end
    end
    chk("t5_granted", int'(hit), 1);
    chk("t5_idx", int'(grant_idx_o), 6);
    drive(8'h40, 0);
    apply_reset(1);
    drive(8'h48, 0);
    chk("t5_first_after_reset", int'(grant_idx_o), 3);

    // Counter saturation, then release coinciding with the hold limit.
    apply_reset(1);
    for (int i = 0; i < 950; i++) drive(8'hFF, 1);
    chk("t6_cnt_sat", int'(grant_cnt_o), 255);
    drive(8'h00, 0);
    drive(8'h00, 0);
    hit = 0;
    for (int i = 0; i < 60; i++) begin
      bit r;
      r = (m_owner >= 0 && m_age == MAX_HOLD - 1);
      drive(8'h20, r);
      if (r) begin hit = 1; break; end
    end
    chk("t6_reached_limit", int'(hit), 1);
    chk("t6_no_timeout", int'(timeout_o), 0);
    chk("t6_valid", int'(grant_valid_o), 0);
    chk("t6_cnt_hold", int'(grant_cnt_o), 255);

    // Randomized traffic with inconsistent-arbiter injections and occasional resets.
    apply_reset(1);
    begin
      logic [7:0] r;
      r = 8'($urandom);
      for (int i = 0; i < 3000; i++) begin
        if ($urandom % 12 == 0) r = 8'($urandom);
        if ($urandom % 500 == 0) apply_reset(1);
        else drive(r, ($urandom % 6) == 0, ($urandom % 10) == 0);
      end
    end

    @(negedge clk);
    #1;
    chk("drain", q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/rr_grant_ctrl.md
Name: rr_grant_ctrl

Overview:
Sequential grant-holding controller that sits directly downstream of the combinational round-robin arbiter. It samples the arbiter's winner index, registers it as a held grant, and keeps it until the owner releases, drops its request, or exceeds a hold limit. It then feeds the winner back to the arbiter as the new low-priority pointer, closing the round-robin loop.

Parameters:
MAX_HOLD, 15, maximum consecutive BUSY cycles per grant before forced release (legal range 1..255)
CNT_W, 8, width of the completed-grant counter

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous, active-high reset
reqs_i  input  8  raw request vector; the same vector drives the arbiter
arb_grant_i  input  3  winner index from the arbiter
arb_any_i  input  1  arbiter has at least one winner
release_i  input  1  current owner finished; sampled only in BUSY
lowp_o  output  3  lowest-priority index (last winner) fed to the arbiter; search starts at lowp_o+1 mod 8
grant_valid_o  output  1  a grant is held this cycle
grant_idx_o  output  3  index of the held grant
grant_onehot_o  output  8  one-hot of grant_idx_o, gated by grant_valid_o
timeout_o  output  1  one-cycle pulse when a grant is forcibly revoked
grant_cnt_o  output  CNT_W  number of completed grants, saturating

Behaviour:
- Reset (asynchronous, active-high) forces:
  - state=IDLE, lowp_o=3'd7 (index 0 has top priority first), grant_valid_o=0, grant_idx_o=0, grant_onehot_o=0, timeout_o=0, grant_cnt_o=0, hold counter=0.
- All outputs are registered. grant_onehot_o is decoded from registered state and has no combinational path from the inputs.
- FSM has three states: IDLE, BUSY, GAP.
- IDLE:
  - If arb_any_i=1 and reqs_i[arb_grant_i]=1: latch grant_idx_o<=arb_grant_i, clear the hold counter, go to BUSY.
  - Otherwise stay in IDLE.
  - Latency is 1 cycle: a request sampled at edge t gives grant_valid_o=1 after edge t.
- BUSY:
  - grant_valid_o=1. The hold counter increments each cycle, 8-bit internal, never wraps because the limit is ≤255.
  - Release condition, in priority order:
    - release_i=1, or
    - reqs_i[grant_idx_o]=0 (requester withdrew), or
    - hold counter = MAX_HOLD-1 (timeout).
  - On any release: go to GAP, lowp_o<=grant_idx_o, and grant_cnt_o<=grant_cnt_o+1, saturating at all-ones.
  - Set timeout_o=1 for that one cycle only if the release is due to the timeout, and release_i=0 and the request is still high.
  - A simultaneous release_i and timeout counts as a normal release, with no timeout_o.
- GAP:
  - grant_valid_o=0 for exactly one cycle, so the arbiter sees the updated lowp_o.
  - Unconditionally return to IDLE.
  - Minimum spacing between two grants is therefore 2 idle cycles (GAP, then IDLE sampling).
- Outside BUSY, changes on release_i and reqs_i are ignored except for the IDLE grant decision.
- If arb_any_i=1 but the indicated request bit is 0 (an inconsistent arbiter), do not grant; stay in IDLE.
- lowp_o changes only on the BUSY→GAP transition.
- Reset asserted mid-BUSY:
  - Outputs drop immediately (asynchronously), with no timeout_o and no count increment.
  - lowp_o returns to 7.
- MAX_HOLD=1 gives single-cycle grants: BUSY lasts exactly one cycle, and timeout_o pulses if the owner neither released nor withdrew.

Test Plan:
1. Reset then reqs_i=8'h01, arbiter gives idx 0 → grant_valid_o=1 and grant_onehot_o=8'h01 one cycle later; release_i pulsed in the 3rd BUSY cycle → grant_valid_o=0 next cycle, lowp_o=0, grant_cnt_o=1, timeout_o never high.
2. reqs_i=8'hFF held, release_i pulsed each BUSY cycle with the arbiter in the loop → grants in order 0,1,2,…,7,0, each separated by one GAP and one IDLE cycle; lowp_o follows 0..7.
3. reqs_i=8'h20 held, release_i=0, MAX_HOLD=15 → grant_idx_o=5 for exactly 15 cycles, timeout_o pulses once on the last BUSY edge, lowp_o=5, then regrant to 5 after the GAP/IDLE cycles.
4. Grant to idx 3, then reqs_i[3] drops to 0 in BUSY cycle 2 → release next edge, timeout_o=0, grant_cnt_o increments, lowp_o=3.
5. rst asserted mid-BUSY with grant_idx_o=6 → grant_valid_o=0, grant_onehot_o=0, lowp_o=7, grant_cnt_o=0 without waiting for a clock edge; the first grant after reset goes to the lowest active index.
6. Run 300 short grants with CNT_W=8 → grant_cnt_o saturates at 255 and stays there; release_i and the timeout arriving in the same cycle → timeout_o=0.
